// File: rtl/new_usb_ohci_roothub.sv
// new_usb_ohci_roothub
//   Root-hub downstream port controller: one state machine per port handling
//   connect/disconnect debounce, timed SE0 port reset, enable/suspend/resume,
//   and HcRhPortStatus-style status and sticky change bits.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   line_state_i        per-port {dp,dm}, synchronised; 00 SE0, 10 FS J, 01 LS J
//   cmd_valid_i/port/op command strobe, target port, opcode (always accepted)
//   cmd_clr_mask_i      ClearChange W1C mask {PRSC,PSSC,PESC,CSC}
//   ccs/pes/pss/prs/lsda_o  current status per port
//   csc/pesc/pssc/prsc_o    sticky change bits per port
//   drive_se0_o/drive_k_o   PHY reset / resume signalling requests
//   rhsc_o              OR of all change bits
module new_usb_ohci_roothub #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned DebounceCycles = 100,
  parameter int unsigned ResetCycles    = 600,
  parameter int unsigned ResumeCycles   = 400,
  parameter int unsigned CntWidth       = $clog2(
    ((DebounceCycles > ResetCycles)
      ? ((DebounceCycles > ResumeCycles) ? DebounceCycles : ResumeCycles)
      : ((ResetCycles > ResumeCycles) ? ResetCycles : ResumeCycles)) + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*NumPorts-1:0] line_state_i,
  input  logic                  cmd_valid_i,
  input  logic [3:0]            cmd_port_i,
  input  logic [2:0]            cmd_op_i,
  input  logic [3:0]            cmd_clr_mask_i,
  output logic [NumPorts-1:0]   ccs_o,
  output logic [NumPorts-1:0]   pes_o,
  output logic [NumPorts-1:0]   pss_o,
  output logic [NumPorts-1:0]   prs_o,
  output logic [NumPorts-1:0]   lsda_o,
  output logic [NumPorts-1:0]   csc_o,
  output logic [NumPorts-1:0]   pesc_o,
  output logic [NumPorts-1:0]   pssc_o,
  output logic [NumPorts-1:0]   prsc_o,
  output logic [NumPorts-1:0]   drive_se0_o,
  output logic [NumPorts-1:0]   drive_k_o,
  output logic                  rhsc_o
);

  typedef enum logic [2:0] {
    ST_DISCONNECTED,
    ST_DEBOUNCE,
    ST_DISABLED,
    ST_RESETTING,
    ST_ENABLED,
    ST_SUSPENDED,
    ST_RESUMING
  } port_state_e;

  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_SET_RESET    = 3'd1,
    OP_SET_ENABLE   = 3'd2,
    OP_CLR_ENABLE   = 3'd3,
    OP_SET_SUSPEND  = 3'd4,
    OP_CLR_SUSPEND  = 3'd5,
    OP_CLR_CHANGE   = 3'd6
  } cmd_op_e;

  localparam logic [CntWidth-1:0] DebLast = CntWidth'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] RstLast = CntWidth'(ResetCycles - 1);
  localparam logic [CntWidth-1:0] ResLast = CntWidth'(ResumeCycles - 1);

  port_state_e         state_q [NumPorts];
  port_state_e         state_d [NumPorts];
  logic [CntWidth-1:0] cnt_q   [NumPorts];
  logic [CntWidth-1:0] cnt_d   [NumPorts];

  logic [NumPorts-1:0] ccs_q, ccs_d, pes_q, pes_d, pss_q, pss_d, prs_q, prs_d;
  logic [NumPorts-1:0] lsda_q, lsda_d;
  logic [NumPorts-1:0] csc_q, csc_d, pesc_q, pesc_d, pssc_q, pssc_d, prsc_q, prsc_d;
  logic [NumPorts-1:0] se0drv_q, se0drv_d, kdrv_q, kdrv_d;
  logic                rhsc_q, rhsc_d;

  always_comb begin
    logic [1:0] ls;
    logic       se0;
    logic       hit;
    logic       disc;
    logic [3:0] clr;   // {PRSC,PSSC,PESC,CSC}
    logic [3:0] set;   // {PRSC,PSSC,PESC,CSC}
    ccs_d    = ccs_q;
    pes_d    = pes_q;
    pss_d    = pss_q;
    prs_d    = prs_q;
    lsda_d   = lsda_q;
    csc_d    = csc_q;
    pesc_d   = pesc_q;
    pssc_d   = pssc_q;
    prsc_d   = prsc_q;
    se0drv_d = se0drv_q;
    kdrv_d   = kdrv_q;
    ls       = '0;
    se0      = 1'b0;
    hit      = 1'b0;
    disc     = 1'b0;
    clr      = '0;
    set      = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      ls         = line_state_i[2*p +: 2];
      se0        = (ls == 2'b00);
      hit        = cmd_valid_i && (cmd_port_i == 4'(p));
      disc       = 1'b0;
      clr        = '0;
      set        = '0;

      // Line-driven behaviour first; commands below may override it.
      unique case (state_q[p])
        ST_DISCONNECTED: begin
          if (!se0) begin
            state_d[p] = ST_DEBOUNCE;
            cnt_d[p]   = '0;
          end
        end
        ST_DEBOUNCE: begin
          if (se0) begin
            state_d[p] = ST_DISCONNECTED;
            cnt_d[p]   = '0;
          end else if (cnt_q[p] == DebLast) begin
            state_d[p] = ST_DISABLED;
            cnt_d[p]   = '0;
            ccs_d[p]   = 1'b1;
            lsda_d[p]  = (ls == 2'b01);
            set[0]     = 1'b1;
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        ST_DISABLED, ST_ENABLED, ST_SUSPENDED: begin
          if (!se0) begin
            cnt_d[p] = '0;
          end else if (cnt_q[p] == DebLast) begin
            disc       = 1'b1;
            state_d[p] = ST_DISCONNECTED;
            cnt_d[p]   = '0;
            ccs_d[p]   = 1'b0;
            pes_d[p]   = 1'b0;
            pss_d[p]   = 1'b0;
            lsda_d[p]  = 1'b0;
            set[0]     = 1'b1;
            set[1]     = pes_q[p];
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        ST_RESETTING: begin
          if (cnt_q[p] == RstLast) begin
            state_d[p]  = ST_ENABLED;
            cnt_d[p]    = '0;
            prs_d[p]    = 1'b0;
            pes_d[p]    = 1'b1;
            se0drv_d[p] = 1'b0;
            set[3]      = 1'b1;
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        ST_RESUMING: begin
          if (cnt_q[p] == ResLast) begin
            state_d[p] = ST_ENABLED;
            cnt_d[p]   = '0;
            pss_d[p]   = 1'b0;
            kdrv_d[p]  = 1'b0;
            set[2]     = 1'b1;
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        default: begin
          state_d[p] = ST_DISCONNECTED;
          cnt_d[p]   = '0;
        end
      endcase

      // A disconnect completing this cycle drops any command to the port.
      if (hit && !disc) begin
        unique case (cmd_op_i)
          OP_SET_RESET: begin
            if (!ccs_q[p]) begin
              set[0] = 1'b1;
            end else if (state_q[p] inside {ST_DISABLED, ST_ENABLED, ST_SUSPENDED}) begin
              state_d[p]  = ST_RESETTING;
              cnt_d[p]    = '0;
              prs_d[p]    = 1'b1;
              pss_d[p]    = 1'b0;
              se0drv_d[p] = 1'b1;
            end
          end
          OP_SET_ENABLE: begin
            if (!ccs_q[p]) begin
              set[0] = 1'b1;
            end else if (state_q[p] == ST_DISABLED) begin
              state_d[p] = ST_ENABLED;
              cnt_d[p]   = '0;
              pes_d[p]   = 1'b1;
            end
          end
          OP_CLR_ENABLE: begin
            if (state_q[p] inside {ST_ENABLED, ST_SUSPENDED}) begin
              state_d[p] = ST_DISABLED;
              cnt_d[p]   = '0;
              pes_d[p]   = 1'b0;
              pss_d[p]   = 1'b0;
            end
          end
          OP_SET_SUSPEND: begin
            if (state_q[p] == ST_ENABLED) begin
              state_d[p] = ST_SUSPENDED;
              cnt_d[p]   = '0;
              pss_d[p]   = 1'b1;
            end
          end
          OP_CLR_SUSPEND: begin
            if (state_q[p] == ST_SUSPENDED) begin
              state_d[p] = ST_RESUMING;
              cnt_d[p]   = '0;
              kdrv_d[p]  = 1'b1;
            end
          end
          OP_CLR_CHANGE: clr = cmd_clr_mask_i;
          default: ;
        endcase
      end

      // Hardware set wins over a simultaneous software clear.
      csc_d[p]  = (csc_q[p]  & ~clr[0]) | set[0];
      pesc_d[p] = (pesc_q[p] & ~clr[1]) | set[1];
      pssc_d[p] = (pssc_q[p] & ~clr[2]) | set[2];
      prsc_d[p] = (prsc_q[p] & ~clr[3]) | set[3];
    end
    rhsc_d = |{csc_d, pesc_d, pssc_d, prsc_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        state_q[p] <= ST_DISCONNECTED;
        cnt_q[p]   <= '0;
      end
      ccs_q    <= '0;
      pes_q    <= '0;
      pss_q    <= '0;
      prs_q    <= '0;
      lsda_q   <= '0;
      csc_q    <= '0;
      pesc_q   <= '0;
      pssc_q   <= '0;
      prsc_q   <= '0;
      se0drv_q <= '0;
      kdrv_q   <= '0;
      rhsc_q   <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
      ccs_q    <= ccs_d;
      pes_q    <= pes_d;
      pss_q    <= pss_d;
      prs_q    <= prs_d;
      lsda_q   <= lsda_d;
      csc_q    <= csc_d;
      pesc_q   <= pesc_d;
      pssc_q   <= pssc_d;
      prsc_q   <= prsc_d;
      se0drv_q <= se0drv_d;
      kdrv_q   <= kdrv_d;
      rhsc_q   <= rhsc_d;
    end
  end

  assign ccs_o       = ccs_q;
  assign pes_o       = pes_q;
  assign pss_o       = pss_q;
  assign prs_o       = prs_q;
  assign lsda_o      = lsda_q;
  assign csc_o       = csc_q;
  assign pesc_o      = pesc_q;
  assign pssc_o      = pssc_q;
  assign prsc_o      = prsc_q;
  assign drive_se0_o = se0drv_q;
  assign drive_k_o   = kdrv_q;
  assign rhsc_o      = rhsc_q;

endmodule

// File: tb/tb_new_usb_ohci_roothub.sv
// Bench for new_usb_ohci_roothub: directed scenarios followed by random line
// and command traffic, all compared each cycle against a status-bit model.
module tb_new_usb_ohci_roothub;
  localparam int NP  = 2;
  localparam int DEB = 4;
  localparam int RST = 8;
  localparam int RES = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*NP-1:0] line;
  logic          cmd_valid;
  logic [3:0]    cmd_port;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_mask;
  logic [NP-1:0] ccs, pes, pss, prs, lsda, csc, pesc, pssc, prsc, dse0, dk;
  logic          rhsc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  new_usb_ohci_roothub #(
    .NumPorts(NP), .DebounceCycles(DEB), .ResetCycles(RST), .ResumeCycles(RES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .line_state_i(line),
    .cmd_valid_i(cmd_valid), .cmd_port_i(cmd_port), .cmd_op_i(cmd_op),
    .cmd_clr_mask_i(cmd_mask),
    .ccs_o(ccs), .pes_o(pes), .pss_o(pss), .prs_o(prs), .lsda_o(lsda),
    .csc_o(csc), .pesc_o(pesc), .pssc_o(pssc), .prsc_o(prsc),
    .drive_se0_o(dse0), .drive_k_o(dk), .rhsc_o(rhsc)
  );

  // Model: the status bits themselves describe the port; run lengths of
  // stable line samples and absolute completion times replace counters.
  logic [NP-1:0] m_ccs, m_pes, m_pss, m_prs, m_lsda, m_csc, m_pesc, m_pssc, m_prsc, m_se0, m_k;
  logic          m_rhsc;
  int            nrun [NP];
  int            srun [NP];
  int            deadline [NP];
  int            cyc = 0;

  task automatic model_step();
    cyc++;
    if (rst) begin
      {m_ccs, m_pes, m_pss, m_prs, m_lsda, m_csc, m_pesc, m_pssc, m_prsc, m_se0, m_k} = '0;
      m_rhsc = 1'b0;
      for (int p = 0; p < NP; p++) begin
        nrun[p] = 0;
        srun[p] = 0;
      end
      return;
    end
    for (int p = 0; p < NP; p++) begin
      logic [1:0] ln    = line[2*p +: 2];
      bit         se0   = (ln == 2'b00);
      bit         o_ccs = m_ccs[p];
      bit         o_pes = m_pes[p];
      bit         o_pss = m_pss[p];
      bit         o_prs = m_prs[p];
      bit         o_k   = m_k[p];
      bit         hit   = cmd_valid && (int'(cmd_port) == p);
      bit         disc  = 0;
      bit [3:0]   setb  = '0;
      bit [3:0]   clrb  = '0;
      if (!o_ccs) begin
        nrun[p] = se0 ? 0 : nrun[p] + 1;
        if (nrun[p] == DEB + 1) begin
          m_ccs[p] = 1; m_lsda[p] = (ln == 2'b01); setb[0] = 1;
          nrun[p] = 0; srun[p] = 0;
        end
      end else if (o_prs) begin
        if (cyc == deadline[p]) begin
          m_prs[p] = 0; m_pes[p] = 1; m_se0[p] = 0; setb[3] = 1; srun[p] = 0;
        end
      end else if (o_k) begin
        if (cyc == deadline[p]) begin
          m_pss[p] = 0; m_k[p] = 0; setb[2] = 1; srun[p] = 0;
        end
      end else begin
        srun[p] = se0 ? srun[p] + 1 : 0;
        if (srun[p] == DEB) begin
          disc = 1;
          m_ccs[p] = 0; m_pes[p] = 0; m_pss[p] = 0; m_lsda[p] = 0;
          setb[0] = 1; setb[1] = o_pes;
          nrun[p] = 0; srun[p] = 0;
        end
      end
      if (hit && !disc) begin
        case (cmd_op)
          3'd1: if (!o_ccs) setb[0] = 1;
                else if (!o_prs && !o_k) begin
                  m_prs[p] = 1; m_pss[p] = 0; m_se0[p] = 1;
                  deadline[p] = cyc + RST; srun[p] = 0;
                end
          3'd2: if (!o_ccs) setb[0] = 1;
                else if (!o_pes && !o_prs && !o_k) begin
                  m_pes[p] = 1; srun[p] = 0;
                end
          3'd3: if (o_ccs && o_pes && !o_prs && !o_k) begin
                  m_pes[p] = 0; m_pss[p] = 0; srun[p] = 0;
                end
          3'd4: if (o_ccs && o_pes && !o_pss && !o_prs && !o_k) begin
                  m_pss[p] = 1; srun[p] = 0;
                end
          3'd5: if (o_pss && !o_prs && !o_k) begin
                  m_k[p] = 1; deadline[p] = cyc + RES; srun[p] = 0;
                end
          3'd6: clrb = cmd_mask;
          default: ;
        endcase
      end
      m_csc[p]  = (m_csc[p]  & ~clrb[0]) | setb[0];
      m_pesc[p] = (m_pesc[p] & ~clrb[1]) | setb[1];
      m_pssc[p] = (m_pssc[p] & ~clrb[2]) | setb[2];
      m_prsc[p] = (m_prsc[p] & ~clrb[3]) | setb[3];
    end
    m_rhsc = |{m_csc, m_pesc, m_pssc, m_prsc};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("ccs", ccs, m_ccs);
    chk("pes", pes, m_pes);
    chk("pss", pss, m_pss);
    chk("prs", prs, m_prs);
    chk("lsda", lsda, m_lsda);
    chk("csc", csc, m_csc);
    chk("pesc", pesc, m_pesc);
    chk("pssc", pssc, m_pssc);
    chk("prsc", prsc, m_prsc);
    chk("drive_se0", dse0, m_se0);
    chk("drive_k", dk, m_k);
    chk("rhsc", rhsc, m_rhsc);
    chk("se0_k_exclusive", dse0 & dk, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] port, input logic [3:0] mask);
    cmd_valid = 1'b1; cmd_op = op; cmd_port = port; cmd_mask = mask;
    tick();
    cmd_valid = 1'b0; cmd_op = '0; cmd_port = '0; cmd_mask = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; line = '0; cmd_valid = 1'b0; cmd_port = '0; cmd_op = '0; cmd_mask = '0;
    ticks(2);
    chk("reset_ccs", ccs, 2'b00);
    chk("reset_rhsc", rhsc, 1'b0);
    rst = 1'b0;

    // Full-speed connect on port 1.
    line[3:2] = 2'b10;
    ticks(DEB);
    chk("connect_early_ccs", ccs, 2'b00);
    tick();
    chk("connect_ccs", ccs, 2'b10);
    chk("connect_csc", csc, 2'b10);
    chk("connect_lsda", lsda, 2'b00);
    chk("connect_rhsc", rhsc, 1'b1);

    // Bounce on port 0, then ClearChange landing on the connect completion.
    line[1:0] = 2'b10; ticks(3);
    line[1:0] = 2'b00; tick();
    chk("bounce_csc", csc[0], 1'b0);
    line[1:0] = 2'b10; ticks(DEB);
    chk("bounce_ccs_pending", ccs[0], 1'b0);
    cmd(3'd6, 4'd0, 4'b0001);
    chk("clr_vs_connect_csc", csc[0], 1'b1);
    chk("clr_vs_connect_ccs", ccs[0], 1'b1);
    cmd(3'd6, 4'd0, 4'b0001);
    cmd(3'd6, 4'd1, 4'b0001);
    chk("csc_cleared", csc, 2'b00);

    // Port reset on port 0.
    cmd(3'd1, 4'd0, 4'b0000);
    n = int'(dse0[0]);
    chk("reset_prs", prs[0], 1'b1);
    for (int i = 0; i < RST + 2; i++) begin
      tick();
      n += int'(dse0[0]);
    end
    chk("reset_len", n, RST);
    chk("reset_pes", pes[0], 1'b1);
    chk("reset_prsc", prsc[0], 1'b1);
    cmd(3'd6, 4'd0, 4'b1000);
    chk("prsc_cleared", prsc[0], 1'b0);
    chk("rhsc_cleared", rhsc, 1'b0);

    // Port 1: disconnect, reconnect low-speed, enable, suspend, resume.
    line[3:2] = 2'b00; ticks(DEB);
    chk("p1_disc_ccs", ccs[1], 1'b0);
    chk("p1_disc_pesc", pesc[1], 1'b0);
    line[3:2] = 2'b01; ticks(DEB + 1);
    chk("p1_ls_lsda", lsda[1], 1'b1);
    cmd(3'd2, 4'd1, 4'b0000);
    chk("p1_enable", pes[1], 1'b1);
    chk("p1_enable_pesc", pesc[1], 1'b0);
    cmd(3'd4, 4'd1, 4'b0000);
    chk("p1_suspend", pss[1], 1'b1);
    cmd(3'd5, 4'd1, 4'b0000);
    n = int'(dk[1]);
    for (int i = 0; i < RES + 3; i++) begin
      tick();
      n += int'(dk[1]);
    end
    chk("resume_len", n, RES);
    chk("resume_pss", pss[1], 1'b0);
    chk("resume_pssc", pssc[1], 1'b1);

    // Disconnect while port 0 is enabled, then a reset request with CCS=0.
    line[1:0] = 2'b00; ticks(DEB);
    chk("disc_ccs", ccs[0], 1'b0);
    chk("disc_pes", pes[0], 1'b0);
    chk("disc_csc", csc[0], 1'b1);
    chk("disc_pesc", pesc[0], 1'b1);
    cmd(3'd1, 4'd0, 4'b0000);
    chk("disc_reset_se0", dse0[0], 1'b0);
    chk("disc_reset_prs", prs[0], 1'b0);

    // Out-of-range port.
    cmd(3'd6, 4'd5, 4'b1111);
    cmd(3'd3, 4'd5, 4'b0000);
    chk("oor_csc", csc, 2'b11);
    chk("oor_pes", pes, 2'b10);

    // Reset asserted in the middle of port-reset signalling.
    line[1:0] = 2'b10; ticks(DEB + 1);
    cmd(3'd1, 4'd0, 4'b0000);
    ticks(2);
    chk("midreset_se0_before", dse0[0], 1'b1);
    rst = 1'b1; tick();
    chk("midreset_se0", dse0, 2'b00);
    chk("midreset_ccs", ccs, 2'b00);
    chk("midreset_rhsc", rhsc, 1'b0);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(9) == 0) begin
          case ($urandom_range(2))
            0: line[2*p +: 2] = 2'b00;
            1: line[2*p +: 2] = 2'b10;
            default: line[2*p +: 2] = 2'b01;
          endcase
        end
      end
      cmd_valid = ($urandom_range(3) == 0);
      cmd_port  = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1));
      cmd_op    = 3'($urandom_range(7));
      cmd_mask  = 4'($urandom_range(15));
      rst       = ($urandom_range(599) == 0);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/new_usb_ohci_roothub.md
# new_usb_ohci_roothub

Parametrised root-hub port controller for the NewUSB OHCI. It replaces the fixed two-port, tied-off PHY handling with one state machine per downstream port, covering connect debounce, timed port reset, enable/suspend/resume, and OHCI HcRhPortStatus-style status and change bits. It sits between the register file, which issues commands and reads status, and the per-port PHY line sampling.

## Interface
- NumPorts, 2: number of downstream ports, legal range 1..15.
- DebounceCycles, 100: consecutive stable cycles needed to declare a connect or disconnect; must be ≥ 2.
- ResetCycles, 600: duration of SE0 port-reset signalling, in clk_i cycles; must be ≥ 2.
- ResumeCycles, 400: duration of K resume signalling, in clk_i cycles; must be ≥ 2.
- CntWidth, $clog2(max(DebounceCycles,ResetCycles,ResumeCycles)+1): width of each per-port counter (derived).

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- line_state_i  in  NumPorts×2  per-port {dp,dm}, already synchronised to clk_i. 00 = SE0, 10 = FS J, 01 = LS J.
- cmd_valid_i  in  1  command strobe; always accepted, no ready.
- cmd_port_i  in  4  target port index.
- cmd_op_i  in  3  command: 0 NOP, 1 SetPortReset, 2 SetPortEnable, 3 ClearPortEnable, 4 SetPortSuspend, 5 ClearPortSuspend, 6 ClearChange.
- cmd_clr_mask_i  in  4  for ClearChange: write-1-to-clear mask {PRSC,PSSC,PESC,CSC}.
- ccs_o, pes_o, pss_o, prs_o, lsda_o  out  NumPorts each  current status bits.
- csc_o, pesc_o, pssc_o, prsc_o  out  NumPorts each  sticky change bits.
- drive_se0_o  out  NumPorts  PHY drives SE0 (reset signalling).
- drive_k_o  out  NumPorts  PHY drives K (resume signalling).
- rhsc_o  out  1  OR of all change bits; root-hub status-change interrupt.

## Operation
- Each port has states DISCONNECTED, DEBOUNCE, DISABLED, RESETTING, ENABLED, SUSPENDED and RESUMING, plus one CntWidth counter. The counter clears on every state entry.
- **DISCONNECTED:** a non-SE0 sample moves the port to DEBOUNCE.
- **DEBOUNCE:**
  - An SE0 sample returns the port to DISCONNECTED.
  - Otherwise the counter increments.
  - At counter == DebounceCycles-1 with non-SE0, the port moves to DISABLED and sets CCS=1, CSC=1, and LSDA=(line==01).
- **Disconnect detect (DISABLED, ENABLED, SUSPENDED):**
  - The counter counts consecutive SE0 samples; any non-SE0 sample clears it.
  - At DebounceCycles-1 the port moves to DISCONNECTED and sets CCS=0, CSC=1, PES=0, PSS=0 and LSDA=0.
  - PESC=1 is set only if PES was 1.
- **SetPortReset:**
  - With CCS=1 in DISABLED, ENABLED or SUSPENDED: the port moves to RESETTING with PRS=1, PSS=0 and drive_se0=1.
  - With CCS=0: CSC=1 and the state is unchanged.
  - Ignored while RESETTING or RESUMING.
- **RESETTING:**
  - line_state_i is ignored.
  - At counter == ResetCycles-1 the port moves to ENABLED with PRS=0, PRSC=1, PES=1 and drive_se0=0.
- **SetPortEnable:** DISABLED → ENABLED with PES=1 and no PESC. With CCS=0: CSC=1 only.
- **ClearPortEnable:** ENABLED or SUSPENDED → DISABLED with PES=0, PSS=0 and no PESC.
- **SetPortSuspend:** ENABLED → SUSPENDED with PSS=1.
- **ClearPortSuspend:** SUSPENDED → RESUMING with drive_k=1.
- **RESUMING:**
  - At counter == ResumeCycles-1 the port moves to ENABLED with PSS=0, PSSC=1 and drive_k=0.
  - line_state_i is ignored.
- **ClearChange:** clears the change bits selected by the mask. A hardware set in the same cycle wins.
- A command whose cmd_port_i ≥ NumPorts, or that is illegal for the current state, is a no-op with no change bit set (except the CCS=0 cases above).
- A disconnect completion and a command to the same port in the same cycle: the disconnect wins and the command is dropped.
- drive_se0_o and drive_k_o are never high simultaneously.

## Timing
- **Reset:** while rst_i is high at a clk_i edge, every port goes to DISCONNECTED and every output is 0. A reset mid-RESETTING or mid-RESUMING aborts signalling on the next edge.
- **Registered outputs:** all outputs come from registers. rhsc_o is the registered OR, updated in the same cycle as the change bits.
- **Connect:** first non-SE0 sample at edge t; CCS/CSC are visible after edge t+DebounceCycles.
- **Disconnect:** first SE0 sample at edge t (counter was 0); CCS=0 is visible after edge t+DebounceCycles-1.
- **Reset/resume duration:** a command accepted at edge t makes PRS/drive_se0 (or drive_k) visible after t. Completion updates are visible after edge t+ResetCycles (or t+ResumeCycles), giving exactly that many signalling cycles.
- **Command latency:** one cycle for all status effects.

## Test plan
- **Connect:** NumPorts=2, DebounceCycles=4. Port1 line 10 held → ccs_o=10b and csc_o=10b after 4 edges, lsda_o=00, rhsc_o=1.
- **Bounce:** line 10 for 3 cycles, SE0 for 1, then 10 held → CCS only after 4 further stable cycles. No CSC during the bounce.
- **Port reset:** connected port0, SetPortReset, ResetCycles=8 → drive_se0_o[0]=1 and prs_o[0]=1 for exactly 8 cycles, then pes_o[0]=1 and prsc_o[0]=1. ClearChange mask 1000 → prsc_o[0]=0 and rhsc_o=0 (after the earlier CSC has also been cleared).
- **Suspend/resume:** enabled LS port (line 01, lsda=1), SetPortSuspend → pss=1. ClearPortSuspend, ResumeCycles=5 → drive_k=1 for 5 cycles, then pss=0 and pssc=1.
- **Disconnect while enabled:** SE0 for DebounceCycles → ccs=0, pes=0, csc=1, pesc=1. SetPortReset afterwards → only CSC stays set, no drive_se0.
- **Edge cases:**
  - cmd_port_i=5 with NumPorts=2 → no change.
  - rst_i asserted mid-reset → drive_se0_o=0 next cycle and all status bits 0.
  - ClearChange coinciding with a connect completion → csc stays 1.
